// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, control and TERC4 code words,
// the aligner state type and a small phase helper.
package tmds_pkg;

  localparam int TMDS_WORD_BITS = 10;

  // Control-period tokens, named by the {C1,C0} value they carry
  localparam logic [TMDS_WORD_BITS-1:0] CTRL_00 = 10'h354;
  localparam logic [TMDS_WORD_BITS-1:0] CTRL_01 = 10'h0AB;
  localparam logic [TMDS_WORD_BITS-1:0] CTRL_10 = 10'h154;
  localparam logic [TMDS_WORD_BITS-1:0] CTRL_11 = 10'h2AB;

  // TERC4 code words for data-island decoding, indexed by the 4-bit nibble
  localparam logic [TMDS_WORD_BITS-1:0] TERC4_CODES [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2,
    10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6,
    10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // True when the word is one of the four control tokens
  function automatic logic is_ctrl_token(input logic [TMDS_WORD_BITS-1:0] w);
    return (w == CTRL_00) || (w == CTRL_01) || (w == CTRL_10) || (w == CTRL_11);
  endfunction

  // Next bit phase, wrapping 9 -> 0 so the phase stays inside one word
  function automatic logic [3:0] next_phase(input logic [3:0] p);
    return (p == 4'd9) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_channel_aligner.sv
// Single-channel TMDS word aligner: 20-bit sliding window, control-token
// hunt over bit phases 0..9, SEARCH/VERIFY/LOCKED hysteresis.
// Optional per-channel slip/unlock statistics under TMDS_ALIGN_SLIP_STATS_EN.
module tmds_channel_aligner
  import tmds_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LOCK_HITS      = 16,
  parameter int MISS_LIMIT     = 2
) (
  input  logic                      hdmi_clk,
  input  logic                      reset,
  input  logic [TMDS_WORD_BITS-1:0] raw_in,
  output logic [TMDS_WORD_BITS-1:0] aligned_out,
  output logic                      ch_locked,
  output logic [3:0]                phase_out
`ifdef TMDS_ALIGN_SLIP_STATS_EN
  ,
  output logic [15:0]               slip_count,
  output logic [7:0]                unlock_count
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = $clog2(LOCK_HITS + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  logic [TMDS_WORD_BITS-1:0]   prev;
  logic [2*TMDS_WORD_BITS-1:0] window;
  logic [TMDS_WORD_BITS-1:0]   slice;
  logic                        token;
  logic                        timeout;
  logic                        advance;

  align_state_t state, state_next;
  logic [3:0]    phase, phase_next;
  logic [TW-1:0] tcount, tcount_next;
  logic [HW-1:0] hits, hits_next, hits_inc;
  logic [MW-1:0] misses, misses_next, misses_inc;

  // The newest word sits above the previous one so that a slice starting at
  // bit 'phase' picks up the word that began 'phase' serial bits late.
  assign window     = {raw_in, prev};
  assign slice      = TMDS_WORD_BITS'(window >> phase);
  assign token      = is_ctrl_token(slice);
  assign timeout    = !token && (tcount == TW'(TIMEOUT_CYCLES - 1));
  assign hits_inc   = hits + HW'(1);
  assign misses_inc = misses + MW'(1);
  assign phase_out  = phase;

  // Token-free cycle counter; a token always clears it, even on the timeout cycle
  always_comb begin
    tcount_next = tcount + TW'(1);
    if (token || timeout) begin
      tcount_next = '0;
    end
  end

  // Lock hunt: next state, phase advance and hit/miss bookkeeping
  always_comb begin
    state_next  = state;
    hits_next   = hits;
    misses_next = misses;
    advance     = 1'b0;
    case (state)
      SEARCH: begin
        if (token) begin
          if (LOCK_HITS == 1) begin
            state_next  = LOCKED;
            hits_next   = '0;
            misses_next = '0;
          end else begin
            state_next = VERIFY;
            hits_next  = HW'(1);
          end
        end else if (timeout) begin
          advance = 1'b1;
        end
      end
      VERIFY: begin
        if (token) begin
          if (hits_inc == HW'(LOCK_HITS)) begin
            state_next  = LOCKED;
            hits_next   = '0;
            misses_next = '0;
          end else begin
            hits_next = hits_inc;
          end
        end else if (timeout) begin
          state_next = SEARCH;
          hits_next  = '0;
          advance    = 1'b1;
        end
      end
      LOCKED: begin
        if (token) begin
          misses_next = '0;
        end else if (timeout) begin
          if (misses_inc == MW'(MISS_LIMIT)) begin
            state_next  = SEARCH;
            misses_next = '0;
          end else begin
            misses_next = misses_inc;
          end
        end
      end
      default: begin
        state_next = SEARCH;
        hits_next  = '0;
      end
    endcase
  end

  // Phase only moves on a timeout; losing lock keeps the last good phase
  always_comb begin
    phase_next = phase;
    if (advance) begin
      phase_next = next_phase(phase);
    end
  end

  // State, window history, counters and registered outputs
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      prev        <= '0;
      aligned_out <= '0;
      state       <= SEARCH;
      phase       <= '0;
      tcount      <= '0;
      hits        <= '0;
      misses      <= '0;
      ch_locked   <= 1'b0;
    end else begin
      prev        <= raw_in;
      aligned_out <= slice;
      state       <= state_next;
      phase       <= phase_next;
      tcount      <= tcount_next;
      hits        <= hits_next;
      misses      <= misses_next;
      ch_locked   <= (state_next == LOCKED);
    end
  end

`ifdef TMDS_ALIGN_SLIP_STATS_EN
  logic unlock;

  assign unlock = (state == LOCKED) && (state_next == SEARCH);

  // Saturating counts of phase slips and lock losses for link diagnostics
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      slip_count   <= '0;
      unlock_count <= '0;
    end else begin
      if (advance && (slip_count != '1)) begin
        slip_count <= slip_count + 16'd1;
      end
      if (unlock && (unlock_count != '1)) begin
        unlock_count <= unlock_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: rtl/tmds_word_aligner.sv
// Multi-channel TMDS word-boundary aligner. Each channel hunts its own bit
// phase independently; all_locked is the registered AND of the channel locks.
// Optional statistics ports are enabled by TMDS_ALIGN_SLIP_STATS_EN.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int CHANNELS       = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LOCK_HITS      = 16,
  parameter int MISS_LIMIT     = 2
) (
  input  logic                               hdmi_clk,
  input  logic                               reset,
  input  logic [CHANNELS*TMDS_WORD_BITS-1:0] raw_in,
  output logic [CHANNELS*TMDS_WORD_BITS-1:0] aligned_out,
  output logic [CHANNELS-1:0]                ch_locked,
  output logic                               all_locked,
  output logic [CHANNELS*4-1:0]              phase_out
`ifdef TMDS_ALIGN_SLIP_STATS_EN
  ,
  output logic [CHANNELS*16-1:0]             slip_count,
  output logic [CHANNELS*8-1:0]              unlock_count
`endif
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    tmds_channel_aligner #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .LOCK_HITS      (LOCK_HITS),
      .MISS_LIMIT     (MISS_LIMIT)
    ) u_align (
      .hdmi_clk     (hdmi_clk),
      .reset        (reset),
      .raw_in       (raw_in[c*TMDS_WORD_BITS +: TMDS_WORD_BITS]),
      .aligned_out  (aligned_out[c*TMDS_WORD_BITS +: TMDS_WORD_BITS]),
      .ch_locked    (ch_locked[c]),
      .phase_out    (phase_out[c*4 +: 4])
`ifdef TMDS_ALIGN_SLIP_STATS_EN
      ,
      .slip_count   (slip_count[c*16 +: 16]),
      .unlock_count (unlock_count[c*8 +: 8])
`endif
    );
  end

  // Link-level lock, one cycle behind the per-channel flags
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= &ch_locked;
    end
  end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Bench for tmds_word_aligner: a word-level model of the lock hunt checked
// every cycle, plus directed literal expectations for the key scenarios.
module tb_tmds_word_aligner;

  localparam int CH  = 3;
  localparam int TO  = 64;
  localparam int LH  = 4;
  localparam int ML  = 2;
  localparam int TOK = 'h354;

  localparam int HUNT  = 0;
  localparam int TRIAL = 1;
  localparam int HELD  = 2;

  logic              hdmi_clk = 1'b0;
  logic              reset    = 1'b1;
  logic [CH*10-1:0]  raw_in   = '0;
  logic [CH*10-1:0]  aligned_out;
  logic [CH-1:0]     ch_locked;
  logic              all_locked;
  logic [CH*4-1:0]   phase_out;
`ifdef TMDS_ALIGN_SLIP_STATS_EN
  logic [CH*16-1:0]  slip_count;
  logic [CH*8-1:0]   unlock_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int offs[CH];
  int last_w[CH];

  int m_prev[CH], m_phase[CH], m_mode[CH], m_idle[CH];
  int m_hits[CH], m_miss[CH], m_out[CH], m_slips[CH], m_unlocks[CH];
  bit m_lock[CH];
  bit m_all;

  tmds_word_aligner #(
    .CHANNELS       (CH),
    .TIMEOUT_CYCLES (TO),
    .LOCK_HITS      (LH),
    .MISS_LIMIT     (ML)
  ) dut (
    .hdmi_clk     (hdmi_clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .aligned_out  (aligned_out),
    .ch_locked    (ch_locked),
    .all_locked   (all_locked),
    .phase_out    (phase_out)
`ifdef TMDS_ALIGN_SLIP_STATS_EN
    ,
    .slip_count   (slip_count),
    .unlock_count (unlock_count)
`endif
  );

  always #5 hdmi_clk = ~hdmi_clk;

  function automatic bit is_token(input int w);
    return (w == 'h354) || (w == 'h0AB) || (w == 'h154) || (w == 'h2AB);
  endfunction

  // Word-level model: one step per clock using the words the DUT saw
  always @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_prev[c] = 0; m_phase[c] = 0; m_mode[c] = HUNT; m_idle[c] = 0;
        m_hits[c] = 0; m_miss[c] = 0; m_out[c] = 0; m_lock[c] = 1'b0;
        m_slips[c] = 0; m_unlocks[c] = 0;
      end
      m_all = 1'b0;
    end else begin
      bit all_now;
      all_now = 1'b1;
      for (int c = 0; c < CH; c++) all_now = all_now & m_lock[c];
      for (int c = 0; c < CH; c++) begin
        int raw, win, sl;
        bit tok, tmo, slip;
        raw  = int'(raw_in[c*10 +: 10]);
        win  = (raw << 10) | m_prev[c];
        sl   = (win >> m_phase[c]) & 'h3FF;
        tok  = is_token(sl);
        tmo  = !tok && (m_idle[c] == TO - 1);
        slip = 1'b0;
        m_idle[c] = (tok || tmo) ? 0 : m_idle[c] + 1;
        m_out[c]  = sl;
        m_prev[c] = raw;
        if (m_mode[c] == HUNT) begin
          if (tok) begin
            m_hits[c] = 1;
            m_mode[c] = TRIAL;
            if (LH == 1) begin m_mode[c] = HELD; m_miss[c] = 0; end
          end else if (tmo) slip = 1'b1;
        end else if (m_mode[c] == TRIAL) begin
          if (tok) begin
            m_hits[c] = m_hits[c] + 1;
            if (m_hits[c] == LH) begin m_mode[c] = HELD; m_miss[c] = 0; end
          end else if (tmo) begin
            m_mode[c] = HUNT; m_hits[c] = 0; slip = 1'b1;
          end
        end else begin
          if (tok) m_miss[c] = 0;
          else if (tmo) begin
            m_miss[c] = m_miss[c] + 1;
            if (m_miss[c] == ML) begin
              m_mode[c] = HUNT; m_miss[c] = 0;
              if (m_unlocks[c] < 255) m_unlocks[c] = m_unlocks[c] + 1;
            end
          end
        end
        if (slip) begin
          m_phase[c] = (m_phase[c] + 1) % 10;
          if (m_slips[c] < 65535) m_slips[c] = m_slips[c] + 1;
        end
        m_lock[c] = (m_mode[c] == HELD);
      end
      m_all = all_now;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge hdmi_clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        checkOutput($sformatf("model aligned ch%0d", c), int'(aligned_out[c*10 +: 10]), m_out[c]);
        checkOutput($sformatf("model phase ch%0d", c), int'(phase_out[c*4 +: 4]), m_phase[c]);
        checkOutput($sformatf("model locked ch%0d", c), int'(ch_locked[c]), int'(m_lock[c]));
`ifdef TMDS_ALIGN_SLIP_STATS_EN
        checkOutput($sformatf("model slips ch%0d", c), int'(slip_count[c*16 +: 16]), m_slips[c]);
        checkOutput($sformatf("model unlocks ch%0d", c), int'(unlock_count[c*8 +: 8]), m_unlocks[c]);
`endif
      end
      checkOutput("model all_locked", int'(all_locked), int'(m_all));
    end
  end

  // Serialise logical words at each channel's bit offset, then one clock
  task automatic applyStimulus(input int w0, input int w1, input int w2);
    int w[CH];
    w = '{w0, w1, w2};
    for (int c = 0; c < CH; c++) begin
      int raw;
      raw = ((w[c] << offs[c]) | (last_w[c] >> (10 - offs[c]))) & 'h3FF;
      raw_in[c*10 +: 10] = 10'(raw);
      last_w[c] = w[c];
    end
    @(posedge hdmi_clk);
    #1;
  endtask

  task automatic doReset(input int o0, input int o1, input int o2);
    reset  = 1'b1;
    raw_in = '0;
    offs   = '{o0, o1, o2};
    last_w = '{0, 0, 0};
    repeat (2) @(posedge hdmi_clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int bw(input int i);
    return ((i % 52) < 12) ? TOK : 0;
  endfunction

  initial begin
    $display("[TB] start");
    doReset(0, 7, 0);
    chk_en = 1'b1;
    checkOutput("reset aligned", int'(aligned_out), 0);
    checkOutput("reset locked", int'(ch_locked), 0);
    checkOutput("reset all_locked", int'(all_locked), 0);
    checkOutput("reset phase", int'(phase_out), 0);

    // Offset 0 bursts on ch0, offset 7 bursts on ch1, constant zero on ch2
    for (int i = 1; i <= 700; i++) begin
      applyStimulus(bw(i - 1), bw(i - 1), 0);
      if (i == 3) checkOutput("ch0 token passthrough", int'(aligned_out[9:0]), 'h354);
      if (i == 4) checkOutput("ch0 not yet locked", int'(ch_locked[0]), 0);
      if (i == 5) begin
        checkOutput("ch0 locks after 4 tokens", int'(ch_locked[0]), 1);
        checkOutput("ch0 phase 0", int'(phase_out[3:0]), 0);
      end
      if (i == 63)  checkOutput("ch2 phase before 1st timeout", int'(phase_out[11:8]), 0);
      if (i == 64)  checkOutput("ch2 phase after 1st timeout", int'(phase_out[11:8]), 1);
      if (i == 319) checkOutput("ch1 phase step 4", int'(phase_out[7:4]), 4);
      if (i == 320) checkOutput("ch1 phase step 5", int'(phase_out[7:4]), 5);
      if (i == 639) checkOutput("ch2 phase 9", int'(phase_out[11:8]), 9);
      if (i == 640) begin
        checkOutput("ch2 phase wrap to 0", int'(phase_out[11:8]), 0);
        checkOutput("ch2 never locks", int'(ch_locked[2]), 0);
      end
    end
    checkOutput("ch1 locked at offset 7", int'(ch_locked[1]), 1);
    checkOutput("ch1 phase 7", int'(phase_out[7:4]), 7);
    checkOutput("all_locked low with ch2 hunting", int'(all_locked), 0);

    // Lock all channels, then remove tokens
    doReset(0, 7, 2);
    for (int i = 1; i <= 600; i++) applyStimulus(bw(i - 1), bw(i - 1), bw(i - 1));
    checkOutput("all channels locked", int'(all_locked), 1);
    for (int i = 0; i < 20; i++) applyStimulus(TOK, TOK, TOK);
    for (int z = 1; z <= 200; z++) begin
      applyStimulus(0, 0, 0);
      if (z == 65)  checkOutput("locked through one timeout", int'(ch_locked), 'h7);
      if (z == 128) checkOutput("locked before second timeout", int'(ch_locked), 'h7);
      if (z == 129) begin
        checkOutput("unlock on second timeout", int'(ch_locked), 0);
        checkOutput("all_locked lags one cycle", int'(all_locked), 1);
        checkOutput("phase kept on unlock", int'(phase_out), 'h270);
      end
      if (z == 130) checkOutput("all_locked falls", int'(all_locked), 0);
    end

    // Token arriving exactly when the idle count reaches 63 in VERIFY
    doReset(0, 0, 0);
    for (int n = 1; n <= 70; n++) begin
      applyStimulus(((n == 1) || (n >= 65 && n <= 67)) ? TOK : 0,
                    ((n == 1) || (n >= 65 && n <= 67)) ? TOK : 0,
                    ((n == 1) || (n >= 65 && n <= 67)) ? TOK : 0);
      if (n == 66) begin
        checkOutput("collision no phase advance", int'(phase_out), 0);
        checkOutput("collision still verifying", int'(ch_locked), 0);
      end
      if (n == 68) checkOutput("collision hits counted to lock", int'(ch_locked), 'h7);
    end

    // Async reset while verifying, then search restarts from phase 0
    doReset(1, 1, 1);
    for (int n = 1; n <= 70; n++) applyStimulus((n <= 66) ? TOK : 0, (n <= 66) ? TOK : 0, (n <= 66) ? TOK : 0);
    checkOutput("verify at phase 1", int'(phase_out), 'h111);
    checkOutput("verify not locked", int'(ch_locked), 0);
`ifdef TMDS_ALIGN_SLIP_STATS_EN
    checkOutput("one slip recorded", int'(slip_count), 'h000100010001);
`endif
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset aligned", int'(aligned_out), 0);
    checkOutput("async reset phase", int'(phase_out), 0);
    checkOutput("async reset locked", int'(ch_locked), 0);
    checkOutput("async reset all_locked", int'(all_locked), 0);
`ifdef TMDS_ALIGN_SLIP_STATS_EN
    checkOutput("async reset slips", int'(slip_count), 0);
`endif
    doReset(0, 0, 0);
    for (int n = 1; n <= 64; n++) begin
      applyStimulus(0, 0, 0);
      if (n == 63) checkOutput("restart phase 0", int'(phase_out), 0);
      if (n == 64) checkOutput("restart first advance", int'(phase_out), 'h111);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
